// File: rtl/div_ratio_meter.sv
// div_ratio_meter: recovers the period and high time of a ref_clk-synchronous
// pulse train (typically a registered divider output) in ref_clk cycles.
// It raises locked after LOCK_CNT consecutive repeats of the same period, and
// a sticky timeout when no rising edge arrives within 2^CNT_W-1 cycles.
module div_ratio_meter #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic             ref_clk,
  input  logic             reset,
  input  logic             clk_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

  state_t           state;
  logic             in_q;
  logic             in_d;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_inc;
  logic [CNT_W-1:0] prev_period;
  logic [3:0]       match;
  logic [3:0]       match_next;

  assign rise = in_q & ~in_d;

  // Two-stage sample of clk_in; the pair gives a one-cycle rising-edge strobe.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      in_q <= 1'b0;
      in_d <= 1'b0;
    end else begin
      in_q <= clk_in;
      in_d <= in_q;
    end
  end

  // Next match count and saturating high-time increment for the current period.
  always_comb begin
    match_next = 4'd0;
    if (cnt == prev_period) begin
      match_next = (match >= LOCK_TGT) ? LOCK_TGT : match + 4'd1;
    end
    hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + CNT_ONE;
  end

  // Measurement state machine: counts rise-to-rise distance, publishes results, tracks lock and timeout.
  always_ff @(posedge ref_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hcnt        <= '0;
      prev_period <= '0;
      match       <= 4'd0;
      period      <= '0;
      high_time   <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        cnt         <= '0;
        hcnt        <= '0;
        match       <= 4'd0;
        prev_period <= '0;
        locked      <= 1'b0;
        timeout     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= WAIT_EDGE;
          end
          WAIT_EDGE: begin
            if (rise) begin
              cnt   <= CNT_ONE;
              hcnt  <= CNT_ONE;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period      <= cnt;
              high_time   <= hcnt;
              meas_valid  <= 1'b1;
              timeout     <= 1'b0;
              prev_period <= cnt;
              match       <= match_next;
              locked      <= (match_next == LOCK_TGT);
              cnt         <= CNT_ONE;
              hcnt        <= CNT_ONE;
            end else if (cnt == CNT_MAX) begin
              timeout <= 1'b1;
              locked  <= 1'b0;
              match   <= 4'd0;
              cnt     <= '0;
              hcnt    <= '0;
              state   <= WAIT_EDGE;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (in_q) begin
                hcnt <= hcnt_inc;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/div_ratio_meter.md
# div_ratio_meter

Measures the period and high time of a divided clock, in `ref_clk` cycles, and flags when the measurement is stable. It sits beside the frequency divider as its checking end: it takes the registered divider output, or any `ref_clk`-synchronous pulse train, and recovers the divide ratio. It also reports lock and timeout status, for on-chip self-test and for the demo bench.

## Interface
- `CNT_W`, default 8: width of the period/high-time counters; maximum measurable period is 2^CNT_W-1.
- `LOCK_CNT`, default 2: number of consecutive matching period measurements required to assert `locked`. Legal range 1..15.
- `ref_clk` input 1: the single clock; all logic runs on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `clk_in` input 1: signal under measurement, synchronous to `ref_clk`; no synchronizer.
- `enable` input 1: 1 = measure; 0 = idle.
- `period` output CNT_W: last measured rise-to-rise distance, in `ref_clk` cycles.
- `high_time` output CNT_W: cycles `clk_in` was sampled high in that same period.
- `meas_valid` output 1: one-cycle pulse, high in the cycle in which `period`/`high_time` are updated.
- `locked` output 1: ratio stable.
- `timeout` output 1: no rising edge within 2^CNT_W-1 cycles; sticky.

## Operation
- Sampling: `in_q` is registered from `clk_in` each edge; `in_d` is registered from `in_q`. `rise = in_q & ~in_d`.
- States:
  - IDLE: entered when `enable`=0.
  - WAIT_EDGE: entered on `enable`=1; waits for the first `rise`.
  - MEASURE: entered on that first `rise`.
- Counters `cnt` and `hcnt`:
  - On `rise` (WAIT_EDGE or MEASURE), `cnt`←1 and `hcnt`←1.
  - Otherwise in MEASURE, `cnt`←`cnt`+1.
  - Otherwise in MEASURE, `hcnt`←`hcnt`+1 when `in_q`=1; `hcnt` saturates at 2^CNT_W-1.
- Measurement, on `rise` in MEASURE:
  - `period`←`cnt`, `high_time`←`hcnt`, `meas_valid`←1, `timeout`←0.
  - `prev_period`←`cnt`.
  - The first `rise` (from WAIT_EDGE) produces no measurement.
- Lock:
  - On each measurement, if `cnt`==`prev_period` then `match`←min(`match`+1, `LOCK_CNT`); otherwise `match`←0.
  - `locked` = (`match`==`LOCK_CNT`), registered in the same cycle as `meas_valid`.
  - A mismatch drops `locked` with that same `meas_valid`.
- Timeout:
  - In MEASURE with `cnt`==2^CNT_W-1 and no `rise`, set `timeout`←1, `locked`←0, `match`←0, and go to WAIT_EDGE.
  - If `rise` and `cnt`==max occur together, the rise wins: a valid measurement of period = max.
- `enable` falling:
  - Go to IDLE; clear `cnt`, `hcnt`, `match`, `prev_period`, `locked`, `timeout`.
  - `period`/`high_time` hold their last values.
  - A `rise` in the same cycle as `enable`=0 is ignored.
- Arithmetic is unsigned CNT_W with no wrap: `cnt` never exceeds max because of the timeout rule.

## Timing
- Reset values: every register 0, including `period`, `high_time`, `meas_valid`, `locked`, `timeout`, `in_q`, `in_d`, `prev_period`, `match`; state = IDLE.
- Reset is asynchronous; a mid-measurement assertion clears everything immediately. After release, the block restarts from IDLE/WAIT_EDGE, depending on `enable`.
- Latency:
  - `clk_in` 0→1 is first sampled into `in_q` at edge E.
  - `meas_valid`, `period` and `high_time` change at edge E+1.
- Periodic 1-cycle pulse every N cycles, N ≥ 2: `period`=N, `high_time`=1.
- 50% square wave of period 2M: `period`=2M, `high_time`=M.
- A constant `clk_in` (e.g. divider n=1 sampled on rising edges) yields no measurement. `timeout` asserts 2^CNT_W-1 cycles after the last rise.
- Minimum resolvable period is 2 (alternating samples).
- `locked` first asserts with measurement number `LOCK_CNT`+1 after a clean start. The first measurement always mismatches, because `prev_period`=0.

## Test plan
- **Pulse train, N=4:** reset, then `enable`=1; drive a 1-high/3-low pulse train with period 4 (divider n=4). Required: `meas_valid` every 4 cycles with `period`=4, `high_time`=1; `locked`=1 on the 3rd `meas_valid` (LOCK_CNT=2).
- **Square wave, period 6:** 3 high/3 low. Required: `period`=6, `high_time`=3, locked after 3 measurements.
- **Ratio change:** lock at N=4, then switch the pulse train to N=5. Required: the first N=5 measurement gives `period`=5 with `locked` dropping in the same cycle; re-lock after two more N=5 periods.
- **Timeout:** CNT_W=4; lock at N=3, then hold `clk_in`=0. Required: `timeout`=1 and `locked`=0 exactly 15 cycles after the last counted rise. Restoring N=3 gives no `meas_valid` on the first rise; the second rise gives `period`=3 and clears `timeout`.
- **Boundary period:** CNT_W=4, period exactly 15. Required: valid measurement `period`=15, no `timeout`.
- **Disable and reset mid-measurement:**
  - `enable`=0 mid-period: `locked`=0, `period` holds 4; re-enable gives no `meas_valid` until the second rise.
  - `reset` pulse mid-period: all outputs 0 immediately, without waiting for a `ref_clk` edge.
